// File: rtl/operator_unit_scheduler_if.sv
// Bundle of requester-side and operator-unit-side signals around the shared
// operator scheduler; the scheduler uses the slave modport, clients/unit the master.
interface operator_unit_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int OP_W    = 3
) ();
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*OP_W-1:0]   req_op;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [DATA_W-1:0]         resp_data;
    logic                      resp_err;
    logic                      resp_ready;
    logic                      op_start;
    logic [OP_W-1:0]           op_code;
    logic [DATA_W-1:0]         op_a;
    logic [DATA_W-1:0]         op_b;
    logic                      op_done;
    logic [DATA_W-1:0]         op_result;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready, op_done, op_result,
        input  req_ready, resp_valid, resp_data, resp_err, op_start, op_code, op_a, op_b
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready, op_done, op_result,
        output req_ready, resp_valid, resp_data, resp_err, op_start, op_code, op_a, op_b
    );
endinterface

// File: rtl/operator_unit_scheduler.sv
// Round-robin scheduler sharing one operator unit between NUM_REQ requesters,
// with a watchdog on the unit's done and a held response handshake.
module operator_unit_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int OP_W    = 3,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    operator_unit_scheduler_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [IDX_W-1:0]    last_r;
    logic [CNT_W-1:0]    wait_cnt_r;
    logic                op_start_r;
    logic [OP_W-1:0]     op_code_r;
    logic [DATA_W-1:0]   op_a_r;
    logic [DATA_W-1:0]   op_b_r;
    logic [NUM_REQ-1:0]  resp_valid_r;
    logic [DATA_W-1:0]   resp_data_r;
    logic                resp_err_r;
    logic                grant_vld_s;
    logic [IDX_W-1:0]    grant_idx_s;
    logic [NUM_REQ-1:0]  req_ready_s;
    logic [OP_W-1:0]     sel_op_s;
    logic [DATA_W-1:0]   sel_a_s;
    logic [DATA_W-1:0]   sel_b_s;
    logic                timeout_s;
    logic                accept_s;

    function automatic logic [IDX_W-1:0] wrap_f(input logic [IDX_W-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end else begin
            sum = sum;
        end
        return sum[IDX_W-1:0];
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot_f(input logic [IDX_W-1:0] idx);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Round-robin pick: first valid requester after the last winner.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = {IDX_W{1'b0}};
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!grant_vld_s && bus.req_valid[wrap_f(last_r, k)]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = wrap_f(last_r, k);
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // Operand mux for the candidate winner.
    always_comb begin
        sel_op_s = {OP_W{1'b0}};
        sel_a_s  = {DATA_W{1'b0}};
        sel_b_s  = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx_s == IDX_W'(i)) begin
                sel_op_s = bus.req_op[i*OP_W +: OP_W];
                sel_a_s  = bus.req_a[i*DATA_W +: DATA_W];
                sel_b_s  = bus.req_b[i*DATA_W +: DATA_W];
            end else begin
                sel_op_s = sel_op_s;
            end
        end
    end

    // Accept pulse is combinational so the requester sees it in its grant cycle.
    always_comb begin
        req_ready_s = {NUM_REQ{1'b0}};
        accept_s    = (state_r == ST_IDLE) && grant_vld_s;
        timeout_s   = (wait_cnt_r == CNT_LAST);
        if (accept_s) begin
            req_ready_s = onehot_f(grant_idx_s);
        end else begin
            req_ready_s = {NUM_REQ{1'b0}};
        end
    end

    // Next-state logic for the IDLE -> ISSUE -> WAIT -> RESP sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_vld_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (bus.op_done || timeout_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register, issue pulse and watchdog counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            op_start_r <= 1'b0;
            wait_cnt_r <= CNT_ZERO;
        end else begin
            state_r    <= state_nxt_s;
            op_start_r <= accept_s;
            if (state_r == ST_ISSUE) begin
                wait_cnt_r <= CNT_ZERO;
            end else if (state_r == ST_WAIT) begin
                wait_cnt_r <= wait_cnt_r + CNT_ONE;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end
    end

    // Operand capture and round-robin pointer update on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_r    <= LAST_INIT;
            op_code_r <= {OP_W{1'b0}};
            op_a_r    <= {DATA_W{1'b0}};
            op_b_r    <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            last_r    <= grant_idx_s;
            op_code_r <= sel_op_s;
            op_a_r    <= sel_a_s;
            op_b_r    <= sel_b_s;
        end
    end

    // Response capture; done takes priority over a simultaneous watchdog expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_r <= {NUM_REQ{1'b0}};
            resp_data_r  <= {DATA_W{1'b0}};
            resp_err_r   <= 1'b0;
        end else if ((state_r == ST_WAIT) && bus.op_done) begin
            resp_valid_r <= onehot_f(last_r);
            resp_data_r  <= bus.op_result;
            resp_err_r   <= 1'b0;
        end else if ((state_r == ST_WAIT) && timeout_s) begin
            resp_valid_r <= onehot_f(last_r);
            resp_data_r  <= {DATA_W{1'b0}};
            resp_err_r   <= 1'b1;
        end else if ((state_r == ST_RESP) && bus.resp_ready) begin
            resp_valid_r <= {NUM_REQ{1'b0}};
        end
    end

    assign bus.req_ready  = req_ready_s;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_data  = resp_data_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.op_start   = op_start_r;
    assign bus.op_code    = op_code_r;
    assign bus.op_a       = op_a_r;
    assign bus.op_b       = op_b_r;
endmodule

// File: tb/tb_operator_unit_scheduler.sv
// Directed bench for operator_unit_scheduler: arbitration order, latency,
// watchdog, done/timeout tie, held response and reset abort.
module tb_operator_unit_scheduler;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int OP_W    = 3;
    localparam int TIMEOUT = 16;
    localparam logic [2:0] OP_EQ = 3'd0;

    logic clk = 1'b0;
    logic reset;
    int   tests_run = 0;
    int   tests_failed = 0;

    logic [3:0]  vld_v;
    logic [2:0]  op_v [4];
    logic [31:0] a_v  [4];
    logic [31:0] b_v  [4];

    operator_unit_scheduler_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .OP_W(OP_W)) bus ();

    operator_unit_scheduler #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .OP_W(OP_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] oh(input int i);
        return 4'b0001 << i;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_op[i*OP_W +: OP_W]     = op_v[i];
            bus.req_a[i*DATA_W +: DATA_W]  = a_v[i];
            bus.req_b[i*DATA_W +: DATA_W]  = b_v[i];
        end
        bus.req_valid = vld_v;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".resp_valid"}, 32'(bus.resp_valid), 32'h0);
        chk({tag, ".op_start"},   32'(bus.op_start),   32'h0);
        chk({tag, ".resp_data"},  bus.resp_data,       32'h0);
        chk({tag, ".resp_err"},   32'(bus.resp_err),   32'h0);
        chk({tag, ".op_code"},    32'(bus.op_code),    32'h0);
        chk({tag, ".op_a"},       bus.op_a,            32'h0);
        chk({tag, ".op_b"},       bus.op_b,            32'h0);
    endtask

    // Expects requester g to be accepted in the current cycle, runs the op with
    // done in WAIT cycle done_d (0 = never) and consumes the response after hold cycles.
    task automatic serve(input int g, input int done_d, input logic [31:0] res,
                         input int hold, input bit drop, input string tag);
        int          lat;
        int          exp_lat;
        logic [31:0] exp_data;
        logic        exp_err;
        #1;
        chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'(oh(g)));
        tick();
        if (drop) vld_v[g] = 1'b0;
        apply();
        chk({tag, ".op_start"}, 32'(bus.op_start), 32'h1);
        chk({tag, ".op_code"},  32'(bus.op_code),  32'(op_v[g]));
        chk({tag, ".op_a"},     bus.op_a,          a_v[g]);
        chk({tag, ".op_b"},     bus.op_b,          b_v[g]);
        lat = 0;
        while (bus.resp_valid == 4'b0000 && lat < TIMEOUT + 4) begin
            tick();
            lat++;
            if (bus.resp_valid == 4'b0000) begin
                chk({tag, ".start_once"}, 32'(bus.op_start), 32'h0);
                bus.op_done   = (lat == done_d);
                bus.op_result = (lat == done_d) ? res : 32'hDEAD_BEEF;
            end else begin
                bus.op_done = 1'b0;
            end
        end
        bus.op_done = 1'b0;
        if (done_d >= 1 && done_d <= TIMEOUT) begin
            exp_lat = done_d + 1; exp_data = res; exp_err = 1'b0;
        end else begin
            exp_lat = TIMEOUT + 1; exp_data = 32'h0; exp_err = 1'b1;
        end
        chk({tag, ".latency"},    32'(lat),            32'(exp_lat));
        chk({tag, ".resp_valid"}, 32'(bus.resp_valid), 32'(oh(g)));
        chk({tag, ".resp_data"},  bus.resp_data,       exp_data);
        chk({tag, ".resp_err"},   32'(bus.resp_err),   32'(exp_err));
        for (int h = 0; h < hold; h++) begin
            tick();
            chk({tag, ".hold_valid"}, 32'(bus.resp_valid), 32'(oh(g)));
            chk({tag, ".hold_data"},  bus.resp_data,       exp_data);
            chk({tag, ".hold_rdy"},   32'(bus.req_ready),  32'h0);
        end
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        chk({tag, ".resp_drop"}, 32'(bus.resp_valid), 32'h0);
    endtask

    initial begin
        op_v[0] = OP_EQ; a_v[0] = 32'h0000_0000; b_v[0] = 32'h0000_0001;
        op_v[1] = 3'd1;  a_v[1] = 32'h0000_0011; b_v[1] = 32'h0000_000F;
        op_v[2] = 3'd2;  a_v[2] = 32'h0000_2222; b_v[2] = 32'h0000_0100;
        op_v[3] = 3'd5;  a_v[3] = 32'h3333_3333; b_v[3] = 32'h0000_0003;
        vld_v = 4'b0000;
        apply();
        bus.resp_ready = 1'b0;
        bus.op_done    = 1'b0;
        bus.op_result  = 32'h0;
        reset = 1'b1;
        tick(); tick(); tick();
        chk_zero("reset");
        chk("reset.req_ready", 32'(bus.req_ready), 32'h0);
        reset = 1'b0;

        // 1: single request from requester 0, one-cycle unit.
        vld_v = 4'b0001; apply();
        serve(0, 1, 32'h0000_0001, 0, 1'b1, "t1");

        // 2: all four held; fresh reset so requester 0 leads.
        reset = 1'b1; tick(); reset = 1'b0;
        vld_v = 4'b1111; apply();
        serve(0, 1, 32'h0000_0100, 0, 1'b0, "t2.g0");
        serve(1, 2, 32'h0000_0101, 0, 1'b0, "t2.g1");
        serve(2, 1, 32'h0000_0102, 0, 1'b0, "t2.g2");
        serve(3, 3, 32'h0000_0103, 0, 1'b0, "t2.g3");
        serve(0, 1, 32'h0000_0104, 0, 1'b0, "t2.g0b");

        // 3: watchdog expiry, requester 3 alone.
        vld_v = 4'b1000; apply();
        serve(3, 0, 32'h0, 0, 1'b1, "t3");

        // 4: done arrives on the final watchdog cycle.
        vld_v = 4'b0010; apply();
        serve(1, TIMEOUT, 32'h0000_00A5, 0, 1'b1, "t4");

        // 5: response held 5 cycles with requester 0 waiting, then back-to-back.
        vld_v = 4'b0101; apply();
        serve(2, 3, 32'hCAFE_0002, 5, 1'b1, "t5");
        serve(0, 2, 32'hCAFE_0000, 0, 1'b1, "t5.b2b");

        // 6: reset during WAIT, stray done, then requester 2.
        vld_v = 4'b0010; apply();
        #1;
        chk("t6.req_ready", 32'(bus.req_ready), 32'(oh(1)));
        tick();
        vld_v = 4'b0000; apply();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_zero("t6.rst");
        chk("t6.rst.req_ready", 32'(bus.req_ready), 32'h0);
        bus.op_done = 1'b1; bus.op_result = 32'h0000_0BAD;
        tick();
        bus.op_done = 1'b0;
        tick();
        chk("t6.stray_valid", 32'(bus.resp_valid), 32'h0);
        chk("t6.stray_start", 32'(bus.op_start),   32'h0);
        vld_v = 4'b0100; apply();
        serve(2, 1, 32'h0000_2122, 0, 1'b1, "t6");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
